// File: rtl/matmul_2x2_seq.sv
// Signed 2x2 matrix product over one shared multiply-accumulate; result 8 cycles after acceptance.
// Valid/ready both sides: no input is taken while computing or while DONE waits on out_ready.
module matmul_2x2_seq #(
   parameter int BIT_PREC = 8,
   parameter int OUT_PREC = 2*BIT_PREC+1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic signed [1:0][1:0][BIT_PREC-1:0] A,
   input  logic signed [1:0][1:0][BIT_PREC-1:0] B,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic signed [1:0][1:0][OUT_PREC-1:0] C
);

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t                        state, state_nxt;
   logic [2:0]                    cnt;
   logic [1:0][1:0][BIT_PREC-1:0] a_q, b_q;
   logic [1:0][1:0][OUT_PREC-1:0] res_q;
   logic signed [OUT_PREC-1:0]    acc, mul_a, mul_b, prod, sum;
   logic                          ei, ej, k;

   // step s walks elements (0,0),(0,1),(1,0),(1,1); low bit selects the inner term
   assign ei = cnt[2];
   assign ej = cnt[1];
   assign k  = cnt[0];

   always_comb begin
      mul_a = OUT_PREC'($signed(a_q[ei][k]));
      mul_b = OUT_PREC'($signed(b_q[k][ej]));
      prod  = mul_a * mul_b;
      sum   = acc + prod;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)     state_nxt = MAC;
         MAC:     if (cnt == 3'd7)  state_nxt = DONE;
         DONE:    if (out_ready)    state_nxt = IDLE;
         default:                   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE) && !rst;
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         cnt   <= '0;
         acc   <= '0;
         res_q <= '0;
         C     <= '0;
      end else if (in_valid && in_ready) begin
         a_q <= A;
         b_q <= B;
         cnt <= '0;
      end else if (state == MAC) begin
         cnt <= cnt + 3'd1;
         if (!k) acc <= prod;
         else    res_q[ei][ej] <= sum;
         // last element is still in flight in sum, so it bypasses the buffer
         if (cnt == 3'd7) begin
            C       <= res_q;
            C[1][1] <= sum;
         end
      end
   end

endmodule

// File: tb/tb_matmul_2x2_seq.sv
// Randomised and directed bench for matmul_2x2_seq against a plain-arithmetic matrix model.
module tb_matmul_2x2_seq;

   localparam int BP = 8;
   localparam int OP = 2*BP+1;

   typedef logic [1:0][1:0][BP-1:0] mat_t;
   typedef logic [1:0][1:0][OP-1:0] cmat_t;

   logic                           clk = 0;
   logic                           rst = 1;
   logic                           in_valid = 0;
   logic                           in_ready;
   logic signed [1:0][1:0][BP-1:0] A = '0;
   logic signed [1:0][1:0][BP-1:0] B = '0;
   logic                           out_valid;
   logic                           out_ready = 0;
   logic signed [1:0][1:0][OP-1:0] C;

   int    total = 0;
   int    bad = 0;
   int    cyc = 0;
   int    acc_q[$];
   cmat_t out_q[$];

   matmul_2x2_seq #(.BIT_PREC(BP), .OUT_PREC(OP)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .C(C)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (out_valid && out_ready) out_q.push_back(C);
   end

   function automatic mat_t mk(input int a00, input int a01, input int a10, input int a11);
      mat_t m;
      m[0][0] = BP'(a00); m[0][1] = BP'(a01); m[1][0] = BP'(a10); m[1][1] = BP'(a11);
      return m;
   endfunction

   function automatic cmat_t mk17(input int c00, input int c01, input int c10, input int c11);
      cmat_t m;
      m[0][0] = OP'(c00); m[0][1] = OP'(c01); m[1][0] = OP'(c10); m[1][1] = OP'(c11);
      return m;
   endfunction

   function automatic mat_t rnd_mat();
      mat_t m;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            m[i][j] = BP'($urandom);
      return m;
   endfunction

   function automatic cmat_t model(input mat_t a, input mat_t b);
      cmat_t r;
      int    s;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            s = 0;
            for (int kk = 0; kk < 2; kk++)
               s += int'($signed(a[i][kk])) * int'($signed(b[kk][j]));
            r[i][j] = OP'(s);
         end
      return r;
   endfunction

   // runs one full transaction; lat=-1 signals that a bounded wait expired
   task automatic do_op(input mat_t a, input mat_t b, input int stall,
                        output cmat_t c, output int lat);
      int t0;
      int n;
      lat = -1;
      c   = '0;
      @(negedge clk);
      A = a; B = b; in_valid = 1; out_ready = 0;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      if (!in_ready) begin in_valid = 0; return; end
      @(posedge clk); #1 t0 = cyc;
      @(negedge clk); in_valid = 0;
      n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      if (!out_valid) return;
      lat = cyc - t0;
      c = C;
      repeat (stall) @(negedge clk);
      out_ready = 1;
      @(posedge clk);
      @(negedge clk); out_ready = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (C !== cmat_t'(0)) begin bad++; $display("FAIL reset_c got=%h exp=0", C); end
      @(posedge clk); #2 rst = 0;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_handoff();
      cmat_t c;
      int    lat;
      do_op(mk(9, 18, -2, 0), mk(1, 2, 3, 4), 0, c, lat);
      total++; if (c !== mk17(63, 90, -2, -4)) begin bad++; $display("FAIL handoff_c got=%h exp=%h", c, mk17(63, 90, -2, -4)); end
      total++; if (lat !== 8) begin bad++; $display("FAIL handoff_latency got=%0d exp=8", lat); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL handoff_valid_width got=%b exp=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL handoff_ready_back got=%b exp=1", in_ready); end
   endtask

   task automatic test_extremes();
      cmat_t c;
      int    lat;
      do_op(mk(-128, -128, -128, -128), mk(-128, -128, -128, -128), 1, c, lat);
      total++; if (c !== mk17(32768, 32768, 32768, 32768)) begin bad++; $display("FAIL extreme_neg got=%h exp=%h", c, mk17(32768, 32768, 32768, 32768)); end
      do_op(mk(-128, -128, -128, -128), mk(127, 127, 127, 127), 0, c, lat);
      total++; if (c !== mk17(-32512, -32512, -32512, -32512)) begin bad++; $display("FAIL extreme_mixed got=%h exp=%h", c, mk17(-32512, -32512, -32512, -32512)); end
   endtask

   task automatic test_backpressure();
      mat_t  a, b;
      cmat_t c0, exp;
      int    n;
      int    unstable;
      a = rnd_mat(); b = rnd_mat(); exp = model(a, b);
      @(negedge clk);
      A = a; B = b; in_valid = 1; out_ready = 0;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      @(negedge clk); in_valid = 0;
      n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      c0 = C;
      total++; if (c0 !== exp) begin bad++; $display("FAIL bp_result got=%h exp=%h", c0, exp); end
      unstable = 0;
      for (int i = 0; i < 5; i++) begin
         if (out_valid !== 1'b1 || C !== c0 || in_ready !== 1'b0) unstable++;
         A = rnd_mat(); B = rnd_mat(); in_valid = (i == 2);
         @(negedge clk);
      end
      in_valid = 0;
      total++; if (unstable !== 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", unstable); end
      total++; if (C !== c0) begin bad++; $display("FAIL bp_hold_c got=%h exp=%h", C, c0); end
      out_ready = 1;
      @(posedge clk);
      @(negedge clk); out_ready = 0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_transfer got=%b exp=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_pulse_ignored got=%b exp=1", in_ready); end
   endtask

   task automatic test_back_to_back();
      int n;
      acc_q.delete(); out_q.delete();
      @(negedge clk);
      A = mk(1, 0, 0, 1); B = mk(5, -6, 7, 8); in_valid = 1; out_ready = 1;
      n = 0;
      while (acc_q.size() < 1 && n < 50) begin @(negedge clk); n++; end
      A = mk(1, 1, 1, 1); B = mk(2, 3, 4, 5);
      n = 0;
      while (acc_q.size() < 2 && n < 50) begin @(negedge clk); n++; end
      in_valid = 0;
      n = 0;
      while (out_q.size() < 2 && n < 50) begin @(negedge clk); n++; end
      out_ready = 0;
      total++;
      if (acc_q.size() != 2 || out_q.size() != 2) begin
         bad++; $display("FAIL b2b_counts got acc=%0d out=%0d exp=2/2", acc_q.size(), out_q.size());
      end else begin
         if (acc_q[1] - acc_q[0] !== 10) begin bad++; $display("FAIL b2b_spacing got=%0d exp=10", acc_q[1] - acc_q[0]); end
         total++; if (out_q[0] !== mk17(5, -6, 7, 8)) begin bad++; $display("FAIL b2b_first got=%h exp=%h", out_q[0], mk17(5, -6, 7, 8)); end
         total++; if (out_q[1] !== mk17(6, 8, 6, 8)) begin bad++; $display("FAIL b2b_second got=%h exp=%h", out_q[1], mk17(6, 8, 6, 8)); end
      end
   endtask

   task automatic test_input_change();
      mat_t  a, b;
      cmat_t exp;
      int    n;
      for (int r = 0; r < 3; r++) begin
         a = rnd_mat(); b = rnd_mat(); exp = model(a, b);
         @(negedge clk);
         A = a; B = b; in_valid = 1; out_ready = 0;
         n = 0;
         while (!in_ready && n < 50) begin @(negedge clk); n++; end
         @(posedge clk);
         n = 0;
         do begin
            @(negedge clk);
            A = rnd_mat(); B = rnd_mat(); in_valid = 1'($urandom);
            n++;
         end while (!out_valid && n < 50);
         in_valid = 0;
         total++; if (C !== exp) begin bad++; $display("FAIL input_change_%0d got=%h exp=%h", r, C, exp); end
         out_ready = 1;
         @(posedge clk);
         @(negedge clk); out_ready = 0;
      end
   endtask

   task automatic test_reset_mid();
      mat_t  a, b;
      cmat_t c, exp;
      int    n, lat, stale;
      a = rnd_mat(); b = rnd_mat();
      @(negedge clk);
      A = a; B = b; in_valid = 1; out_ready = 1;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      @(negedge clk); in_valid = 0;
      repeat (3) @(posedge clk);
      #2 rst = 1;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
      total++; if (C !== cmat_t'(0)) begin bad++; $display("FAIL rstmid_c got=%h exp=0", C); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_in_ready got=%b exp=0", in_ready); end
      @(posedge clk); #2 rst = 0;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_release got=%b exp=1", in_ready); end
      stale = 0;
      repeat (15) begin @(negedge clk); if (out_valid !== 1'b0) stale++; end
      out_ready = 0;
      total++; if (stale !== 0) begin bad++; $display("FAIL rstmid_stale got=%0d exp=0", stale); end
      a = rnd_mat(); b = rnd_mat(); exp = model(a, b);
      do_op(a, b, 0, c, lat);
      total++; if (c !== exp) begin bad++; $display("FAIL rstmid_next got=%h exp=%h", c, exp); end
   endtask

   task automatic test_random();
      mat_t  a, b;
      cmat_t c, exp;
      int    lat;
      for (int r = 0; r < 8; r++) begin
         a = rnd_mat(); b = rnd_mat(); exp = model(a, b);
         do_op(a, b, $urandom_range(0, 3), c, lat);
         total++; if (c !== exp) begin bad++; $display("FAIL random_%0d got=%h exp=%h", r, c, exp); end
         total++; if (lat !== 8) begin bad++; $display("FAIL random_lat_%0d got=%0d exp=8", r, lat); end
      end
   endtask

   initial begin
      test_reset();
      test_handoff();
      test_extremes();
      test_backpressure();
      test_back_to_back();
      test_input_change();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/matmul_2x2_seq.md
# matmul_2x2_seq

Sequential signed 2x2 matrix multiplier sitting directly downstream of the combinational 2x2 matrix subtractor in the Strassen datapath. It consumes a difference matrix plus a second operand and produces the full-precision 2x2 product. It uses one shared multiply-accumulate unit over 8 cycles, with valid/ready handshakes on both sides.

## Interface
Parameters:
- BIT_PREC, 8, signed operand width; matches the subtractor output width.
- OUT_PREC, 2*BIT_PREC+1, signed result width; overflow-free for any operand values.

Ports:
- clk, input, 1, the only clock; all state updates on its rising edge.
- rst, input, 1, asynchronous, active-high reset.
- in_valid, input, 1, A and B hold a valid operand pair.
- in_ready, output, 1, block accepts an operand pair this cycle.
- A, input, [2][2] x BIT_PREC signed, left operand matrix (from the subtractor's C).
- B, input, [2][2] x BIT_PREC signed, right operand matrix.
- out_valid, output, 1, C holds a completed product.
- out_ready, input, 1, consumer accepts C this cycle.
- C, output, [2][2] x OUT_PREC signed, product A x B.

## Operation
- States:
  - IDLE: in_ready=1.
  - MAC: 8 cycles.
  - DONE: out_valid=1.
- IDLE -> MAC on in_valid && in_ready. A and B are captured into internal registers on that edge. Later changes on the A/B inputs have no effect.
- MAC step counter s = 0..7:
  - Element index e = s[2:1], in order (0,0), (0,1), (1,0), (1,1).
  - Inner index k = s[0].
  - On k=0: acc <= A[i][0]*B[0][j].
  - On k=1: result[i][j] <= acc + A[i][1]*B[1][j].
- MAC -> DONE after step 7. The internal result buffer is copied into C on that same edge.
- DONE -> IDLE on out_ready. C keeps its value until the next DONE entry.
- Arithmetic:
  - Products are sign-extended to OUT_PREC before the add.
  - No saturation and no truncation.
  - Worst case (-2^(BIT_PREC-1))^2 * 2 = 32768 fits in 17 bits signed.
- in_ready is low in MAC and DONE. An in_valid asserted there is ignored and not queued.
- out_ready asserted outside DONE is ignored.
- in_ready is forced 0 while rst is asserted.
- Reset, including mid-MAC or mid-DONE:
  - Takes effect immediately (asynchronous).
  - state=IDLE, out_valid=0, C=0, counter=0, acc=0, result buffer=0, captured operands=0.
  - Any in-flight computation is discarded. No out_valid follows.

## Timing
- Reset values:
  - in_ready=0 during rst, and 1 on the first cycle after rst deasserts.
  - out_valid=0.
  - All C elements 0.
- Latency:
  - Input handshake at edge T.
  - MAC steps are performed at edges T+1..T+8.
  - out_valid=1 and C valid from edge T+8, i.e. 8 cycles after acceptance.
- Output handshake:
  - Transfer at the first edge with out_valid && out_ready, at edge T+8+n where n >= 1 is the stall length.
  - out_valid drops and in_ready rises after that edge.
- Throughput:
  - Back-to-back with out_ready held high: one result per 10 cycles (1 IDLE, 8 MAC, 1 DONE).
  - The next input can be accepted at the edge after the DONE transfer.
- C and out_valid are stable throughout DONE regardless of A, B and in_valid activity.

## Test plan
- Subtractor handoff:
  - Stimulus: A=[[9,18],[-2,0]], B=[[1,2],[3,4]], out_ready=1.
  - Required: C=[[63,90],[-2,-4]].
  - Required: out_valid rises exactly 8 cycles after acceptance and stays high for 1 cycle.
- Extremes:
  - Stimulus: all A and B elements = -128.
  - Required: every C element = 32768, with no sign wrap.
  - Stimulus: A all -128, B all 127.
  - Required: every C element = -32512.
- Backpressure:
  - Stimulus: out_ready held low for 5 cycles after out_valid rises.
  - Required: C and out_valid stay constant, in_ready stays 0, and a new in_valid pulse with different A/B is ignored.
  - Required: the transfer completes on the first out_ready edge.
- Back-to-back:
  - Stimulus: identity x [[5,-6],[7,8]], then [[1,1],[1,1]] x [[2,3],[4,5]], with in_valid held high and out_ready=1.
  - Required: results [[5,-6],[7,8]] then [[6,8],[6,8]].
  - Required: acceptance edges exactly 10 cycles apart.
- Input change after capture:
  - Stimulus: change A/B on every cycle during MAC.
  - Required: the result matches the values captured at the handshake.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle at MAC step 4, asynchronously between clock edges.
  - Required: out_valid=0 and C=0 immediately.
  - Required: in_ready=1 on the first cycle after release, and no stale out_valid ever appears.
  - Required: the next operation produces a correct result.
